// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared types and constants for the RV32M multiply/divide unit.
//   muldiv_op_e    : operation encoding, identical to the funct3 field
//   muldiv_state_e : sequencer states of muldiv_unit
//   MD_WIDTH       : operand/result width (only 32 is supported)
//   DIV0_QUOT      : quotient returned for a divide by zero
//   SIGNED_MIN     : most negative signed value, used for overflow detection
//   negate_if      : helper returning -v when neg is set, else v
package muldiv_pkg;

   localparam int MD_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } muldiv_state_e;

   localparam logic [MD_WIDTH-1:0] DIV0_QUOT  = {MD_WIDTH{1'b1}};
   localparam logic [MD_WIDTH-1:0] SIGNED_MIN = {1'b1, {(MD_WIDTH-1){1'b0}}};

   // Two's complement negation when requested; used both to take magnitudes
   // at capture and to re-apply signs at the end of an operation.
   function automatic logic [MD_WIDTH-1:0] negate_if(input logic [MD_WIDTH-1:0] v,
                                                     input logic neg);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
// One radix-2 iteration of the shared multiply/divide datapath (purely
// combinational). The accumulator is {hi, lo}:
//   multiply : hi = partial product, lo = remaining multiplier bits
//   divide   : hi = partial remainder, lo = dividend bits shifting into the
//              remainder while quotient bits shift in from the bottom
// Ports:
//   acc      in   2*WIDTH  current accumulator
//   operand  in   WIDTH    multiplicand (multiply) or divisor (divide)
//   div_mode in   1        1 = compare-subtract, 0 = shift-add
//   acc_next out  2*WIDTH  next accumulator; for divide the LSB is left 0
//   q_bit    out  1        quotient bit of this step (0 in multiply mode),
//                          to be placed into the LSB of acc_next by the caller
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   input  logic               div_mode,
   output logic [2*WIDTH-1:0] acc_next,
   output logic               q_bit
);

   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] rem_sub;
   logic             ge;

   assign hi = acc[2*WIDTH-1:WIDTH];
   assign lo = acc[WIDTH-1:0];

   // Multiply adds the multiplicand when the current multiplier bit is set and
   // then shifts the whole 2*WIDTH+1 bit result right, so the carry of the add
   // lands in the top bit. Divide shifts the next dividend bit into the partial
   // remainder and subtracts the divisor if it fits. The remainder is always
   // below the divisor, so a successful subtraction fits back into WIDTH bits
   // and the truncated difference is exact.
   always_comb begin
      sum      = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      shifted  = {hi, lo[WIDTH-1]};
      ge       = (shifted >= {1'b0, operand});
      rem_sub  = shifted[WIDTH-1:0] - operand;
      q_bit    = 1'b0;
      acc_next = {sum, lo[WIDTH-1:1]};
      if (div_mode) begin
         q_bit    = ge;
         acc_next = {(ge ? rem_sub : shifted[WIDTH-1:0]), lo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative RV32M multiply/divide unit sitting between the register file read
// ports and its write port. A start pulse while idle captures the operands,
// operation and destination; the result is returned with a one-cycle done /
// write-enable strobe. busy stays high for the whole operation so the core
// can stall on it.
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset
//   start     in   1      request, ignored while busy
//   funct3    in   3      operation (MUL..REMU)
//   rs1_data  in   WIDTH  operand A (multiplicand / dividend)
//   rs2_data  in   WIDTH  operand B (multiplier / divisor)
//   rd_addr   in   5      destination register index
//   busy      out  1      high whenever the unit is not idle
//   done      out  1      one-cycle result-valid pulse
//   wb_en     out  1      register write strobe, suppressed for x0
//   wb_addr   out  5      captured destination index
//   result    out  WIDTH  write-back data, held until the next done
// Build option:
//   MULDIV_FAST_MUL_EN  when defined, multiplies complete in a single-cycle
//                       combinational multiplier at capture (IDLE -> DONE);
//                       divides always use the iterative path.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] rs1_data,
   input  logic [WIDTH-1:0] rs2_data,
   input  logic [4:0]       rd_addr,
   output logic             busy,
   output logic             done,
   output logic             wb_en,
   output logic [4:0]       wb_addr,
   output logic [WIDTH-1:0] result
);

   muldiv_state_e      state;
   muldiv_state_e      state_next;
   muldiv_op_e         op;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] step_acc;
   logic               step_q;
   logic [WIDTH-1:0]   opb;
   logic [4:0]         cnt;
   logic               neg_main;
   logic               neg_rem;

   logic               is_div;
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic               special;
   logic [WIDTH-1:0]   special_result;
   logic               fast_mul;
   logic [WIDTH-1:0]   fast_result;

   logic [2*WIDTH-1:0] product_fixed;
   logic [WIDTH-1:0]   quot_fixed;
   logic [WIDTH-1:0]   rem_fixed;
   logic [WIDTH-1:0]   fix_result;

   // Decode the incoming request: which operands are treated as signed, their
   // magnitudes, and whether the answer is known immediately (divide by zero
   // or the single signed-overflow case DIV/REM of SIGNED_MIN by -1).
   always_comb begin
      is_div = funct3[2];
      sign_a = 1'b0;
      sign_b = 1'b0;
      unique case (muldiv_op_e'(funct3))
         OP_MULH, OP_DIV, OP_REM: begin
            sign_a = rs1_data[WIDTH-1];
            sign_b = rs2_data[WIDTH-1];
         end
         OP_MULHSU: sign_a = rs1_data[WIDTH-1];
         default:   ;
      endcase
      mag_a          = negate_if(rs1_data, sign_a);
      mag_b          = negate_if(rs2_data, sign_b);
      special        = 1'b0;
      special_result = '0;
      if (is_div && (rs2_data == '0)) begin
         special        = 1'b1;
         special_result = funct3[1] ? rs1_data : DIV0_QUOT;
      end else if (is_div && !funct3[0] && (rs1_data == SIGNED_MIN) && (rs2_data == '1)) begin
         special        = 1'b1;
         special_result = funct3[1] ? '0 : SIGNED_MIN;
      end
   end

`ifdef MULDIV_FAST_MUL_EN
   logic signed [WIDTH:0]     fast_a;
   logic signed [WIDTH:0]     fast_b;
   logic        [2*WIDTH-1:0] fast_product;

   // Single-cycle multiplier. The extension bit equals the operand sign only
   // for operands treated as signed, so one signed multiplier covers all four
   // multiply flavours; the low 2*WIDTH bits of the product are exact.
   always_comb begin
      fast_a       = {sign_a, rs1_data};
      fast_b       = {sign_b, rs2_data};
      fast_product = (2*WIDTH)'(fast_a * fast_b);
      fast_mul     = !funct3[2];
      fast_result  = (funct3 == 3'b000) ? fast_product[WIDTH-1:0]
                                        : fast_product[2*WIDTH-1:WIDTH];
   end
`else
   assign fast_mul    = 1'b0;
   assign fast_result = '0;
`endif

   muldiv_step #(
      .WIDTH    (WIDTH)
   ) u_step (
      .acc      (acc),
      .operand  (opb),
      .div_mode (op[2]),
      .acc_next (step_acc),
      .q_bit    (step_q)
   );

   // Sign correction applied after the last iteration. For multiplies the
   // full product is negated (MUL never records signs, so its low half is the
   // plain unsigned product). For divides the quotient takes sign(A) XOR
   // sign(B) and the remainder takes sign(A).
   always_comb begin
      product_fixed = neg_main ? -acc : acc;
      quot_fixed    = negate_if(acc[WIDTH-1:0], neg_main);
      rem_fixed     = negate_if(acc[2*WIDTH-1:WIDTH], neg_rem);
      unique case (op)
         OP_MUL:          fix_result = product_fixed[WIDTH-1:0];
         OP_DIV, OP_DIVU: fix_result = quot_fixed;
         OP_REM, OP_REMU: fix_result = rem_fixed;
         default:         fix_result = product_fixed[2*WIDTH-1:WIDTH];
      endcase
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Sequencer: special cases and fast multiplies jump straight to DONE,
   // everything else runs WIDTH iterations in CALC followed by one FIX cycle.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_next = (special || fast_mul) ? DONE : CALC;
            end
         end
         CALC: begin
            if (cnt == 5'(WIDTH-1)) begin
               state_next = FIX;
            end
         end
         FIX:     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers. Capture loads the magnitudes so the iterations work
   // unsigned: multiply keeps the multiplier in the low half and the
   // multiplicand in opb, divide keeps the dividend in the low half and the
   // divisor in opb. result only changes when a new answer becomes valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op       <= OP_MUL;
         acc      <= '0;
         opb      <= '0;
         cnt      <= '0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
         wb_addr  <= '0;
         result   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  op       <= muldiv_op_e'(funct3);
                  wb_addr  <= rd_addr;
                  cnt      <= '0;
                  neg_main <= sign_a ^ sign_b;
                  neg_rem  <= sign_a;
                  if (is_div) begin
                     acc <= {{WIDTH{1'b0}}, mag_a};
                     opb <= mag_b;
                  end else begin
                     acc <= {{WIDTH{1'b0}}, mag_b};
                     opb <= mag_a;
                  end
                  if (special) begin
                     result <= special_result;
                  end else if (fast_mul) begin
                     result <= fast_result;
                  end
               end
            end
            CALC: begin
               acc <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
               cnt <= cnt + 5'd1;
            end
            FIX:     result <= fix_result;
            default: ;
         endcase
      end
   end

   assign busy  = (state != IDLE);
   assign done  = (state == DONE);
   assign wb_en = done && (wb_addr != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit: reset values, each operation
// class with hand-computed answers, latency of iterative and special paths,
// ignored start while busy, x0 write suppression and reset mid-operation.
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [4:0]  rd_addr;
   logic        busy;
   logic        done;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] result;

   int checks;
   int errors;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_EDGE = 0;
`else
   localparam int MUL_EDGE = 33;
`endif
   localparam int DIV_EDGE = 33;

   muldiv_unit dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .funct3   (funct3),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .rd_addr  (rd_addr),
      .busy     (busy),
      .done     (done),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .result   (result)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global safety net so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Called at a negedge with the unit idle: presents a request, lets the
   // capture edge take it, then scrambles the operands to prove they were
   // captured.
   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd);
      start    = 1'b1;
      funct3   = f3;
      rs1_data = a;
      rs2_data = b;
      rd_addr  = rd;
      @(posedge clk);
      #1;
      start    = 1'b0;
      rs1_data = $urandom;
      rs2_data = $urandom;
      rd_addr  = 5'($urandom);
      funct3   = 3'($urandom);
   endtask

   // Runs one operation and checks its answer, write-back fields, the edge
   // (relative to capture) after which done appeared, and how long busy stayed up.
   task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_edge);
      int cycles;
      int busy_cnt;
      applyStimulus(f3, a, b, rd);
      cycles   = 0;
      busy_cnt = 0;
      do begin
         @(negedge clk);
         cycles++;
         if (busy) busy_cnt++;
      end while (!done && cycles < 100);
      checkOutput({tag, "/done"}, 32'(done), 32'd1);
      checkOutput({tag, "/done_edge"}, 32'(cycles - 1), 32'(exp_edge));
      checkOutput({tag, "/result"}, result, exp_res);
      checkOutput({tag, "/wb_en"}, 32'(wb_en), 32'(rd != 5'd0));
      checkOutput({tag, "/wb_addr"}, 32'(wb_addr), 32'(rd));
      checkOutput({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(exp_edge + 1));
      @(negedge clk);
      checkOutput({tag, "/back_idle"}, 32'({busy, done, wb_en}), 32'd0);
   endtask

   initial begin
      int done_cnt;
      logic [31:0] seen_res;
      logic [4:0]  seen_addr;
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      start    = 1'b0;
      funct3   = 3'd0;
      rs1_data = '0;
      rs2_data = '0;
      rd_addr  = '0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset/outputs", 32'({busy, done, wb_en}), 32'd0);
      checkOutput("reset/wb_addr", 32'(wb_addr), 32'd0);
      checkOutput("reset/result", result, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] multiply group");
      runOp("mul_7x-3",      3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, MUL_EDGE);
      runOp("mulhu_max",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, MUL_EDGE);
      runOp("mulh_-1x-1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, MUL_EDGE);
      runOp("mulh_-2x3",     3'b001, 32'hFFFFFFFE, 32'h00000003, 5'd3,  32'hFFFFFFFF, MUL_EDGE);
      runOp("mulhsu_-1x2",   3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd4,  32'hFFFFFFFF, MUL_EDGE);
      runOp("mulhu_big",     3'b011, 32'h80000000, 32'h00000004, 5'd6,  32'h00000002, MUL_EDGE);

      $display("[TB] divide group");
      runOp("div_-7/2",      3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd8,  32'hFFFFFFFD, DIV_EDGE);
      runOp("rem_-7/2",      3'b110, 32'hFFFFFFF9, 32'h00000002, 5'd9,  32'hFFFFFFFF, DIV_EDGE);
      runOp("divu_100/7",    3'b101, 32'd100,      32'd7,        5'd10, 32'd14,       DIV_EDGE);
      runOp("remu_100/7",    3'b111, 32'd100,      32'd7,        5'd11, 32'd2,        DIV_EDGE);
      runOp("div_7/-2",      3'b100, 32'h00000007, 32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, DIV_EDGE);
      runOp("divu_min/-1",   3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, DIV_EDGE);

      $display("[TB] special cases");
      runOp("divu_5/0",      3'b101, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 0);
      runOp("remu_5/0",      3'b111, 32'd5,        32'd0,        5'd15, 32'd5,        0);
      runOp("div_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 0);
      runOp("rem_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h00000000, 0);
      runOp("rd0_remu",      3'b111, 32'd100,      32'd7,        5'd0,  32'd2,        DIV_EDGE);

      $display("[TB] start while busy");
      applyStimulus(3'b101, 32'd100, 32'd7, 5'd3);
      repeat (9) @(posedge clk);
      #1;
      start    = 1'b1;
      funct3   = 3'b000;
      rs1_data = 32'd2;
      rs2_data = 32'd2;
      rd_addr  = 5'd9;
      @(posedge clk);
      #1;
      start     = 1'b0;
      done_cnt  = 0;
      seen_res  = '0;
      seen_addr = '0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            seen_res  = result;
            seen_addr = wb_addr;
         end
      end
      checkOutput("busy_start/done_count", 32'(done_cnt), 32'd1);
      checkOutput("busy_start/result", seen_res, 32'd14);
      checkOutput("busy_start/wb_addr", 32'(seen_addr), 32'd3);
      checkOutput("busy_start/idle", 32'(busy), 32'd0);

      $display("[TB] reset mid-operation");
      applyStimulus(3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd20);
      repeat (15) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midrst/busy", 32'(busy), 32'd0);
      checkOutput("midrst/done", 32'({done, wb_en}), 32'd0);
      checkOutput("midrst/result", result, 32'd0);
      checkOutput("midrst/wb_addr", 32'(wb_addr), 32'd0);
      @(negedge clk);
      rst      = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || wb_en) done_cnt++;
      end
      checkOutput("midrst/no_done", 32'(done_cnt), 32'd0);
      runOp("after_rst_mul", 3'b000, 32'd3, 32'd4, 5'd6, 32'd12, MUL_EDGE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
